// File: rtl/sync_arith_pkg.sv
// Shared opcode encoding and status bit positions for the registered arithmetic unit.
package sync_arith_pkg;

    typedef enum logic [1:0] {
        OP_SUB2B = 2'b00,
        OP_LT    = 2'b01,
        OP_ROL   = 2'b10,
        OP_SM    = 2'b11
    } op_e;

    localparam int ST_ERR  = 0;
    localparam int ST_PAR  = 1;
    localparam int ST_ONES = 2;
    localparam int ST_ZERO = 3;

endpackage

// File: rtl/arith_status_flags.sv
// Combinational status generator: error flag plus parity/all-ones/zero of the result.
module arith_status_flags
    import sync_arith_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0] result,
    input  logic         error,
    input  logic         keep_flags,
    output logic [3:0]   status
);

    // A plain error reports only the error bit; a saturated result still describes itself.
    always_comb begin
        status         = '0;
        status[ST_ERR] = error;
        if (keep_flags) begin
            status[ST_PAR]  = ^result;
            status[ST_ONES] = &result;
            status[ST_ZERO] = (result == '0);
        end
    end

endmodule

// File: rtl/sync_arith_unit.sv
// Registered signed ALU: A-2B, signed compare, rotate-left, sign-magnitude conversion.
// Optional build macro SYNC_ARITH_SATURATE_EN clamps A-2B overflow to +/-LIM.
module sync_arith_unit
    import sync_arith_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [M-1:0] i_arg_A,
    input  logic [M-1:0] i_arg_B,
    input  logic [N-1:0] i_op,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam int SHW = (M > 1) ? $clog2(M) : 1;
    localparam logic signed [M+1:0] LIM_WIDE = {3'b000, {(M-1){1'b1}}};
    localparam logic [M-1:0] LIM_POS = {1'b0, {(M-1){1'b1}}};
    localparam logic [M-1:0] LIM_NEG = ~LIM_POS + M'(1);

    op_e                  op_sel;
    logic signed [M+1:0]  a_wide;
    logic signed [M+1:0]  b_dbl;
    logic signed [M+1:0]  diff;
    logic [2*M-1:0]       rot_wide;
    logic [M-2:0]         a_mag;
    logic [M-1:0]         next_result;
    logic                 next_error;
    logic                 keep_flags;
    logic [3:0]           next_status;

    // A-2B is evaluated two bits wider so it can never wrap before the range check.
    always_comb begin
        op_sel      = op_e'(i_op[1:0]);
        a_wide      = {{2{i_arg_A[M-1]}}, i_arg_A};
        b_dbl       = {i_arg_B[M-1], i_arg_B, 1'b0};
        diff        = a_wide - b_dbl;
        rot_wide    = {i_arg_A, i_arg_A} << i_arg_B[SHW-1:0];
        a_mag       = ~i_arg_A[M-2:0] + (M-1)'(1);
        next_result = '0;
        next_error  = 1'b0;
        keep_flags  = 1'b1;

        case (op_sel)
            OP_SUB2B: begin
                if (diff > LIM_WIDE || diff < -LIM_WIDE) begin
                    next_error = 1'b1;
`ifdef SYNC_ARITH_SATURATE_EN
                    next_result = diff[M+1] ? LIM_NEG : LIM_POS;
`else
                    keep_flags = 1'b0;
`endif
                end else begin
                    next_result = diff[M-1:0];
                end
            end
            OP_LT: begin
                next_result = {{(M-1){1'b0}}, ($signed(i_arg_A) < $signed(i_arg_B))};
            end
            OP_ROL: begin
                next_result = rot_wide[2*M-1:M];
            end
            OP_SM: begin
                // The most negative code has no magnitude representable in M-1 bits.
                if (i_arg_A[M-1] && (i_arg_A[M-2:0] == '0)) begin
                    next_error = 1'b1;
                    keep_flags = 1'b0;
                end else if (i_arg_A[M-1]) begin
                    next_result = {1'b1, a_mag};
                end else begin
                    next_result = i_arg_A;
                end
            end
        endcase
    end

    arith_status_flags #(
        .M(M)
    ) u_flags (
        .result     (next_result),
        .error      (next_error),
        .keep_flags (keep_flags),
        .status     (next_status)
    );

    // The output registers are the only state in the block.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_result <= '0;
            o_status <= '0;
        end else begin
            o_result <= next_result;
            o_status <= next_status;
        end
    end

endmodule

// File: tb/tb_sync_arith_unit.sv
// Self-checking bench for sync_arith_unit (M=4, N=2): directed tables plus random ops vs a reference model.
module tb_sync_arith_unit;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] st;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] arg_a;
    logic [3:0] arg_b;
    logic [1:0] op;
    logic [3:0] result;
    logic [3:0] status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_arith_unit #(
        .N(2),
        .M(4)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .i_arg_A  (arg_a),
        .i_arg_B  (arg_b),
        .i_op     (op),
        .o_result (result),
        .o_status (status)
    );

    // Reference model working on plain signed integers.
    function automatic void ref_model(input logic [1:0] f_op, input logic [3:0] f_a,
                                      input logic [3:0] f_b,
                                      output logic [3:0] f_res, output logic [3:0] f_st);
        int sa;
        int sb;
        int v;
        bit err;
        bit keep;
        sa   = int'($signed(f_a));
        sb   = int'($signed(f_b));
        err  = 1'b0;
        keep = 1'b1;
        v    = 0;
        case (f_op)
            2'd0: begin
                v = sa - 2 * sb;
                if (v > 7 || v < -7) begin
                    err = 1'b1;
`ifdef SYNC_ARITH_SATURATE_EN
                    v = (v > 0) ? 7 : -7;
`else
                    v = 0;
                    keep = 1'b0;
`endif
                end
            end
            2'd1: v = (sa < sb) ? 1 : 0;
            2'd2: begin
                v = int'(f_a);
                for (int k = 0; k < (int'(f_b) % 4); k++) v = ((v << 1) | (v >> 3)) & 15;
            end
            default: begin
                if (sa == -8) begin
                    err = 1'b1;
                    keep = 1'b0;
                    v = 0;
                end else if (sa < 0) begin
                    v = 8 + (-sa);
                end else begin
                    v = sa;
                end
            end
        endcase
        f_res = v[3:0];
        if (!keep) f_st = 4'b0001;
        else f_st = {f_res == 4'd0, f_res == 4'hF, ^f_res, err};
    endfunction

    task automatic applyStimulus(input logic [1:0] t_op, input logic [3:0] t_a, input logic [3:0] t_b);
        op    = t_op;
        arg_a = t_a;
        arg_b = t_b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        op    = 2'b11;
        arg_a = 4'b1011;
        arg_b = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== 4'b0000 || status !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_hold: result=%b status=%b expected 0000/0000", result, status);
        end
        rst_n = 1'b1;
        applyStimulus(2'b11, 4'b1011, 4'b0000);
        checks++;
        if (result !== 4'b1101 || status !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL reset_preload: result=%b status=%b expected 1101/0010", result, status);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 4'b0000 || status !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_async: result=%b status=%b expected 0000/0000", result, status);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(2'b00, 4'b0011, 4'b0001);
        checks++;
        if (result !== 4'b0001 || status !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL reset_release: result=%b status=%b expected 0001/0010", result, status);
        end
    endtask

    task automatic test_sub2b();
        vec_t v[$];
        v.push_back('{2'b00, 4'd3, 4'hF, 4'b0101, 4'b0000});
        v.push_back('{2'b00, 4'd4, 4'd2, 4'b0000, 4'b1000});
        v.push_back('{2'b00, 4'd7, 4'd2, 4'b0011, 4'b0000});
`ifdef SYNC_ARITH_SATURATE_EN
        v.push_back('{2'b00, 4'd4, 4'd6, 4'b1001, 4'b0001});
        v.push_back('{2'b00, 4'hC, 4'd2, 4'b1001, 4'b0001});
        v.push_back('{2'b00, 4'd7, 4'hC, 4'b0111, 4'b0011});
`else
        v.push_back('{2'b00, 4'd4, 4'd6, 4'b0000, 4'b0001});
        v.push_back('{2'b00, 4'hC, 4'd2, 4'b0000, 4'b0001});
        v.push_back('{2'b00, 4'd7, 4'hC, 4'b0000, 4'b0001});
`endif
        foreach (v[i]) begin
            applyStimulus(v[i].op, v[i].a, v[i].b);
            checks++;
            if (result !== v[i].res || status !== v[i].st) begin
                errors++;
                $display("[TB] FAIL sub2b[%0d]: result=%b status=%b expected %b/%b",
                         i, result, status, v[i].res, v[i].st);
            end
        end
    endtask

    task automatic test_lt();
        vec_t v[$];
        v.push_back('{2'b01, 4'd3, 4'd5, 4'b0001, 4'b0010});
        v.push_back('{2'b01, 4'd7, 4'd4, 4'b0000, 4'b1000});
        v.push_back('{2'b01, 4'hC, 4'd3, 4'b0001, 4'b0010});
        v.push_back('{2'b01, 4'hD, 4'hD, 4'b0000, 4'b1000});
        v.push_back('{2'b01, 4'd4, 4'hB, 4'b0000, 4'b1000});
        foreach (v[i]) begin
            applyStimulus(v[i].op, v[i].a, v[i].b);
            checks++;
            if (result !== v[i].res || status !== v[i].st) begin
                errors++;
                $display("[TB] FAIL lt[%0d]: result=%b status=%b expected %b/%b",
                         i, result, status, v[i].res, v[i].st);
            end
        end
    endtask

    task automatic test_rol();
        vec_t v[$];
        v.push_back('{2'b10, 4'b1001, 4'b0001, 4'b0011, 4'b0000});
        v.push_back('{2'b10, 4'b1001, 4'b0110, 4'b0110, 4'b0000});
        v.push_back('{2'b10, 4'b1111, 4'($urandom_range(15)), 4'b1111, 4'b0100});
        v.push_back('{2'b10, 4'b0001, 4'b1011, 4'b1000, 4'b0010});
        foreach (v[i]) begin
            applyStimulus(v[i].op, v[i].a, v[i].b);
            checks++;
            if (result !== v[i].res || status !== v[i].st) begin
                errors++;
                $display("[TB] FAIL rol[%0d]: result=%b status=%b expected %b/%b",
                         i, result, status, v[i].res, v[i].st);
            end
        end
    endtask

    task automatic test_sm();
        vec_t v[$];
        v.push_back('{2'b11, 4'b1011, 4'd0, 4'b1101, 4'b0010});
        v.push_back('{2'b11, 4'b0000, 4'd5, 4'b0000, 4'b1000});
        v.push_back('{2'b11, 4'b1001, 4'd9, 4'b1111, 4'b0100});
        v.push_back('{2'b11, 4'b0011, 4'd3, 4'b0011, 4'b0000});
        v.push_back('{2'b11, 4'b1000, 4'd7, 4'b0000, 4'b0001});
        foreach (v[i]) begin
            applyStimulus(v[i].op, v[i].a, v[i].b);
            checks++;
            if (result !== v[i].res || status !== v[i].st) begin
                errors++;
                $display("[TB] FAIL sm[%0d]: result=%b status=%b expected %b/%b",
                         i, result, status, v[i].res, v[i].st);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] r_op;
        logic [3:0] r_a;
        logic [3:0] r_b;
        logic [3:0] exp_res;
        logic [3:0] exp_st;
        for (int i = 0; i < 200; i++) begin
            r_op = 2'($urandom_range(3));
            r_a  = 4'($urandom_range(15));
            r_b  = 4'($urandom_range(15));
            ref_model(r_op, r_a, r_b, exp_res, exp_st);
            applyStimulus(r_op, r_a, r_b);
            checks++;
            if (result !== exp_res || status !== exp_st) begin
                errors++;
                $display("[TB] FAIL random op=%b a=%b b=%b: result=%b status=%b expected %b/%b",
                         r_op, r_a, r_b, result, status, exp_res, exp_st);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] prev_res;
        logic [3:0] prev_st;
        logic [3:0] exp_res;
        logic [3:0] exp_st;
        logic [3:0] r_a;
        logic [3:0] r_b;
        prev_res = result;
        prev_st  = status;
        for (int i = 0; i < 40; i++) begin
            r_a = 4'($urandom_range(15));
            r_b = 4'($urandom_range(15));
            ref_model(2'(i % 4), r_a, r_b, exp_res, exp_st);
            op    = 2'(i % 4);
            arg_a = r_a;
            arg_b = r_b;
            @(negedge clk);
            checks++;
            if (result !== prev_res || status !== prev_st) begin
                errors++;
                $display("[TB] FAIL b2b_hold[%0d]: result=%b status=%b expected %b/%b",
                         i, result, status, prev_res, prev_st);
            end
            @(posedge clk);
            #1;
            checks++;
            if (result !== exp_res || status !== exp_st) begin
                errors++;
                $display("[TB] FAIL b2b_next[%0d]: result=%b status=%b expected %b/%b",
                         i, result, status, exp_res, exp_st);
            end
            prev_res = exp_res;
            prev_st  = exp_st;
        end
    endtask

    initial begin
        test_reset();
        test_sub2b();
        test_lt();
        test_rol();
        test_sm();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
